// File: rtl/key_event_arbiter.sv
// Turns debounced key levels into press/release events and hands them, one at a
// time and in round-robin key order, to a single req/ack downstream command port.
module key_event_arbiter #(
    parameter int N_KEYS = 4,
    parameter int IDX_W  = 2
) (
    input  logic              i_clk,
    input  logic              i_rst,
    input  logic [N_KEYS-1:0] i_keys,
    input  logic              i_en,
    output logic              o_req,
    output logic [IDX_W-1:0]  o_key_idx,
    output logic              o_press,
    input  logic              i_ack,
    output logic [N_KEYS-1:0] o_pending,
    output logic              o_overrun
);

    typedef enum logic {S_IDLE, S_REQ} state_t;

    state_t              state_q, state_d;
    logic [N_KEYS-1:0]   prev_keys_q;
    logic [N_KEYS-1:0]   pend_p_q, pend_p_d;
    logic [N_KEYS-1:0]   pend_r_q, pend_r_d;
    logic [IDX_W-1:0]    rr_ptr_q, rr_ptr_d;
    logic [IDX_W-1:0]    idx_q, idx_d;
    logic                req_q, req_d;
    logic                press_q, press_d;
    logic                overrun_q, overrun_d;

    logic                ack_fire;
    logic [N_KEYS-1:0]   rise, fall, clr_p, clr_r, ovr_vec, pend_any;
    logic                sel_found;
    logic [IDX_W-1:0]    sel_idx;

    assign ack_fire = (state_q == S_REQ) && i_ack;
    assign pend_any = pend_p_q | pend_r_q;

    // Per-key edge detect, served-bit clear and overrun detection.
    generate
        for (genvar gi = 0; gi < N_KEYS; gi++) begin : g_key
            assign rise[gi]    = i_keys[gi] & ~prev_keys_q[gi];
            assign fall[gi]    = ~i_keys[gi] & prev_keys_q[gi];
            assign clr_p[gi]   = ack_fire && press_q && (idx_q == IDX_W'(gi));
            assign clr_r[gi]   = ack_fire && !press_q && (idx_q == IDX_W'(gi));
            // An edge landing on the bit being acked this cycle is simply re-queued.
            assign ovr_vec[gi] = i_en & ((rise[gi] & pend_p_q[gi] & ~clr_p[gi]) |
                                         (fall[gi] & pend_r_q[gi] & ~clr_r[gi]));
        end
    endgenerate

    always_comb begin
        pend_p_d  = (pend_p_q & ~clr_p) | ({N_KEYS{i_en}} & rise);
        pend_r_d  = (pend_r_q & ~clr_r) | ({N_KEYS{i_en}} & fall);
        overrun_d = overrun_q | (|ovr_vec);
    end

    // Scan downward so the last hit written is the nearest key at or after rr_ptr.
    always_comb begin
        sel_found = 1'b0;
        sel_idx   = '0;
        for (int i = N_KEYS - 1; i >= 0; i--) begin
            int j;
            j = int'(rr_ptr_q) + i;
            if (j >= N_KEYS) begin
                j = j - N_KEYS;
            end
            if (pend_any[j]) begin
                sel_found = 1'b1;
                sel_idx   = IDX_W'(j);
            end
        end
    end

    always_comb begin
        state_d  = state_q;
        req_d    = req_q;
        idx_d    = idx_q;
        press_d  = press_q;
        rr_ptr_d = rr_ptr_q;
        case (state_q)
            S_IDLE: begin
                if (sel_found) begin
                    idx_d   = sel_idx;
                    press_d = pend_p_q[sel_idx];
                    req_d   = 1'b1;
                    state_d = S_REQ;
                end
            end
            S_REQ: begin
                if (i_ack) begin
                    req_d    = 1'b0;
                    state_d  = S_IDLE;
                    rr_ptr_d = (idx_q == IDX_W'(N_KEYS - 1)) ? '0 : idx_q + IDX_W'(1);
                end
            end
        endcase
    end

    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            state_q     <= S_IDLE;
            prev_keys_q <= '0;
            pend_p_q    <= '0;
            pend_r_q    <= '0;
            rr_ptr_q    <= '0;
            idx_q       <= '0;
            req_q       <= 1'b0;
            press_q     <= 1'b0;
            overrun_q   <= 1'b0;
        end else begin
            state_q     <= state_d;
            prev_keys_q <= i_keys;
            pend_p_q    <= pend_p_d;
            pend_r_q    <= pend_r_d;
            rr_ptr_q    <= rr_ptr_d;
            idx_q       <= idx_d;
            req_q       <= req_d;
            press_q     <= press_d;
            overrun_q   <= overrun_d;
        end
    end

    assign o_req     = req_q;
    assign o_key_idx = idx_q;
    assign o_press   = press_q;
    assign o_pending = pend_any;
    assign o_overrun = overrun_q;

endmodule

// File: tb/tb_key_event_arbiter.sv
// Directed bench for key_event_arbiter: expected events go into a queue and a
// negedge monitor checks every req/ack handshake against it.
module tb_key_event_arbiter;

    localparam int N_KEYS = 4;
    localparam int IDX_W  = 2;

    logic              i_clk = 1'b0;
    logic              i_rst;
    logic [N_KEYS-1:0] i_keys;
    logic              i_en;
    logic              i_ack;
    logic              o_req;
    logic [IDX_W-1:0]  o_key_idx;
    logic              o_press;
    logic [N_KEYS-1:0] o_pending;
    logic              o_overrun;

    int checks = 0;
    int fails  = 0;
    logic [IDX_W:0] exp_q[$];
    logic gap_pending = 1'b0;

    key_event_arbiter #(.N_KEYS(N_KEYS), .IDX_W(IDX_W)) dut (
        .i_clk     (i_clk),
        .i_rst     (i_rst),
        .i_keys    (i_keys),
        .i_en      (i_en),
        .o_req     (o_req),
        .o_key_idx (o_key_idx),
        .o_press   (o_press),
        .i_ack     (i_ack),
        .o_pending (o_pending),
        .o_overrun (o_overrun)
    );

    always #5 i_clk = ~i_clk;

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            fails++;
            $display("FAIL %s: got %0h, expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    task automatic tick(input int n);
        repeat (n) @(posedge i_clk);
        #1;
    endtask

    // Expected entry is {key index, press}.
    task automatic expect_ev(input int idx, input logic press);
        exp_q.push_back({IDX_W'(idx), press});
    endtask

    initial begin : monitor
        logic [IDX_W:0] e;
        forever begin
            @(negedge i_clk);
            if (gap_pending) begin
                chk("gap_req_low", {31'd0, o_req}, 32'd0);
                gap_pending = 1'b0;
            end
            if (o_req && i_ack) begin
                chk("idx_in_range", {30'd0, o_key_idx}, {30'd0, o_key_idx} < N_KEYS ? {30'd0, o_key_idx} : 32'hFFFF);
                if (exp_q.size() == 0) begin
                    chk("event_expected", 32'(exp_q.size()), 32'd1);
                end else begin
                    e = exp_q.pop_front();
                    chk("event", {29'd0, o_key_idx, o_press}, {29'd0, e});
                    $display("event key=%0d press=%0d (expected key=%0d press=%0d) t=%0t",
                             o_key_idx, o_press, e[IDX_W:1], e[0], $time);
                end
                gap_pending = 1'b1;
            end
        end
    end

    initial begin : watchdog
        repeat (3000) @(posedge i_clk);
        $display("FAIL watchdog: simulation did not finish within 3000 cycles");
        $fatal(1, "watchdog expired");
    end

    initial begin : stimulus
        i_rst = 1'b1; i_keys = '0; i_en = 1'b1; i_ack = 1'b0;
        tick(3);
        chk("rst_req", {31'd0, o_req}, 32'd0);
        chk("rst_idx", {30'd0, o_key_idx}, 32'd0);
        chk("rst_press", {31'd0, o_press}, 32'd0);
        chk("rst_pending", {28'd0, o_pending}, 32'd0);
        chk("rst_overrun", {31'd0, o_overrun}, 32'd0);
        i_rst = 1'b0;
        tick(1);

        // Single press on key 2: two-cycle latency to o_req.
        expect_ev(2, 1'b1);
        i_keys = 4'b0100;
        tick(1);
        chk("t1_pending", {28'd0, o_pending}, 32'h4);
        chk("t1_req_early", {31'd0, o_req}, 32'd0);
        tick(1);
        chk("t1_req", {31'd0, o_req}, 32'd1);
        chk("t1_idx", {30'd0, o_key_idx}, 32'd2);
        chk("t1_press", {31'd0, o_press}, 32'd1);
        i_ack = 1'b1;
        tick(1);
        chk("t1_req_done", {31'd0, o_req}, 32'd0);
        chk("t1_pending_done", {28'd0, o_pending}, 32'd0);
        i_ack = 1'b0;

        // Round robin from a fresh pointer: keys 0,1,3 then 0,3.
        i_rst = 1'b1; i_keys = '0;
        tick(2);
        i_rst = 1'b0;
        i_ack = 1'b1;
        expect_ev(0, 1'b1); expect_ev(1, 1'b1); expect_ev(3, 1'b1);
        i_keys = 4'b1011;
        tick(10);
        chk("t2_pending", {28'd0, o_pending}, 32'd0);
        i_en = 1'b0; i_keys = 4'b0000;
        tick(1);
        i_en = 1'b1;
        chk("t2_discard", {28'd0, o_pending}, 32'd0);
        expect_ev(0, 1'b1); expect_ev(3, 1'b1);
        i_keys = 4'b1001;
        tick(8);
        chk("t2_pending2", {28'd0, o_pending}, 32'd0);

        // One-cycle pulse on key 1: press then release, no overrun.
        i_ack = 1'b0;
        expect_ev(1, 1'b1); expect_ev(1, 1'b0);
        i_keys = 4'b1011;
        tick(1);
        i_keys = 4'b1001;
        tick(1);
        chk("t3_pending", {28'd0, o_pending}, 32'h2);
        chk("t3_req", {31'd0, o_req}, 32'd1);
        chk("t3_idx", {30'd0, o_key_idx}, 32'd1);
        chk("t3_press_first", {31'd0, o_press}, 32'd1);
        i_ack = 1'b1;
        tick(6);
        i_ack = 1'b0;
        chk("t3_overrun", {31'd0, o_overrun}, 32'd0);
        chk("t3_pending_done", {28'd0, o_pending}, 32'd0);

        // Key 0 up/down/up while its press is unacked: overrun.
        i_en = 1'b0; i_keys = 4'b1000;
        tick(1);
        i_en = 1'b1;
        expect_ev(0, 1'b1); expect_ev(0, 1'b0);
        i_keys = 4'b1001; tick(1);
        i_keys = 4'b1000; tick(1);
        i_keys = 4'b1001; tick(1);
        chk("t4_overrun", {31'd0, o_overrun}, 32'd1);
        chk("t4_pending", {28'd0, o_pending}, 32'h1);
        chk("t4_idx", {30'd0, o_key_idx}, 32'd0);
        i_ack = 1'b1;
        tick(6);
        i_ack = 1'b0;
        chk("t4_pending_done", {28'd0, o_pending}, 32'd0);
        chk("t4_overrun_sticky", {31'd0, o_overrun}, 32'd1);
        i_rst = 1'b1; i_keys = '0;
        tick(1);
        chk("t4_overrun_cleared", {31'd0, o_overrun}, 32'd0);
        i_rst = 1'b0;
        tick(1);

        // Capture disabled: edges discarded, in-flight request still completes.
        i_en = 1'b0;
        i_keys = 4'b1111; tick(1);
        i_keys = 4'b0000; tick(1);
        i_keys = 4'b1111; tick(1);
        i_keys = 4'b0000; tick(1);
        chk("t5_no_req", {31'd0, o_req}, 32'd0);
        chk("t5_no_pending", {28'd0, o_pending}, 32'd0);
        i_en = 1'b1;
        expect_ev(2, 1'b1);
        i_keys = 4'b0100;
        tick(2);
        chk("t5_req", {31'd0, o_req}, 32'd1);
        i_en = 1'b0;
        i_keys = 4'b0101; tick(1);
        i_keys = 4'b0100; tick(1);
        i_keys = 4'b0101; tick(1);
        i_keys = 4'b0100; tick(1);
        chk("t5_pending_held", {28'd0, o_pending}, 32'h4);
        chk("t5_req_held", {31'd0, o_req}, 32'd1);
        chk("t5_idx_held", {30'd0, o_key_idx}, 32'd2);
        i_en = 1'b1;
        i_ack = 1'b1;
        tick(1);
        chk("t5_req_done", {31'd0, o_req}, 32'd0);
        tick(3);
        i_ack = 1'b0;
        chk("t5_pending_done", {28'd0, o_pending}, 32'd0);

        // Reset mid-handshake drops the event; held keys re-fire afterwards.
        i_keys = 4'b0110;
        tick(2);
        chk("t6_req", {31'd0, o_req}, 32'd1);
        chk("t6_idx_rr", {30'd0, o_key_idx}, 32'd1);
        i_rst = 1'b1;
        tick(1);
        chk("t6_rst_req", {31'd0, o_req}, 32'd0);
        chk("t6_rst_pending", {28'd0, o_pending}, 32'd0);
        chk("t6_rst_idx", {30'd0, o_key_idx}, 32'd0);
        i_rst = 1'b0;
        tick(1);
        chk("t6_req_early", {31'd0, o_req}, 32'd0);
        chk("t6_pending", {28'd0, o_pending}, 32'h6);
        expect_ev(1, 1'b1); expect_ev(2, 1'b1);
        tick(1);
        chk("t6_req_after_rst", {31'd0, o_req}, 32'd1);
        chk("t6_idx_after_rst", {30'd0, o_key_idx}, 32'd1);
        chk("t6_press_after_rst", {31'd0, o_press}, 32'd1);
        i_ack = 1'b1;
        tick(6);
        i_ack = 1'b0;
        chk("t6_pending_done", {28'd0, o_pending}, 32'd0);

        tick(2);
        chk("queue_drained", 32'(exp_q.size()), 32'd0);
        $display("End of test - %0d assertions evaluated, %0d failures", checks, fails);
        $finish;
    end

endmodule

// File: doc/key_event_arbiter.md
Name: key_event_arbiter

Overview:
- Converts the debounced switch levels from the per-key debounce blocks into discrete press and release events.
- Holds one pending press event and one pending release event per key.
- Shares a single downstream command port (the I2C command launcher) between all keys, using round-robin arbitration and a req/ack handshake.
- Sits between the debounce stage and the I2C master control logic.

Parameters:
- N_KEYS, 4, number of debounced key inputs (2..16).
- IDX_W, 2, width of the key index; must satisfy 2^IDX_W >= N_KEYS.

Ports:
- i_clk  in  1  system clock.
- i_rst  in  1  synchronous reset, active-high.
- i_keys  in  N_KEYS  debounced key levels, already synchronous to i_clk.
- i_en  in  1  event capture enable.
- o_req  out  1  event valid, held until acknowledged.
- o_key_idx  out  IDX_W  index of the key for the presented event.
- o_press  out  1  event type: 1 = press (rising edge), 0 = release (falling edge).
- i_ack  in  1  downstream accepts the event; only meaningful while o_req=1.
- o_pending  out  N_KEYS  per key, OR of its press-pending and release-pending bits.
- o_overrun  out  1  sticky flag: an event was lost.

Behaviour:
- Reset (i_rst=1 at a clock edge):
  - prev_keys, both pending vectors, rr_ptr, o_req, o_key_idx, o_press and o_overrun all go to 0.
  - FSM goes to IDLE.
  - Reset mid-handshake drops the event; no ack is expected afterwards.
- Edge detect:
  - prev_keys <= i_keys every cycle, independent of i_en.
  - rise[k] = i_keys[k] & ~prev_keys[k]; fall[k] = ~i_keys[k] & prev_keys[k].
  - A key held high through reset produces one press event after reset deasserts.
- Capture (only when i_en=1):
  - rise sets pend_p[k]; fall sets pend_r[k].
  - With i_en=0, edges are discarded, pending bits are kept, and an in-flight request still completes.
- Overrun:
  - Triggered by an edge on a key whose matching pending bit is already set and is not being cleared this cycle.
  - The edge merges into the existing pending bit (nothing extra is queued), and o_overrun is set.
  - o_overrun clears only on reset.
- Same-cycle ack and edge of the same type on the same key: the bit stays set, the new event is retained, and o_overrun is not set.
- FSM IDLE:
  - If any pend_p|pend_r bit is set, select the first key k with a pending bit, scanning from rr_ptr upward with wrap at N_KEYS-1 -> 0.
  - For that key, press takes priority over release.
  - Register o_key_idx=k, o_press=pend_p[k], o_req=1, then go to REQ.
  - If nothing is pending, stay in IDLE.
- FSM REQ:
  - o_req, o_key_idx and o_press stay stable until i_ack=1.
  - On ack: clear the served pending bit, set rr_ptr=(k+1) mod N_KEYS, set o_req=0, return to IDLE.
  - Because of the IDLE return, there is at least one o_req-low cycle between events.
  - i_ack while in IDLE is ignored.
- Latency: an i_keys change sampled at edge t gives pending set at t+1 and o_req=1 at t+2. Maximum event rate is one per 2 cycles.
- Index values >= N_KEYS are never produced.

Test Plan:
- Reset, then raise i_keys[2] and hold it. Expect: o_req=1 two cycles later with o_key_idx=2, o_press=1. Ack in the same cycle. Expect: o_req=0 next cycle and o_pending=0.
- Raise keys 0, 1 and 3 in the same cycle with i_ack tied high. Expect: events served in order 0, 1, 3 with an o_req-low gap between each. Then raise key 0 again and key 3 again. Expect: rr_ptr=0, so the order is 0 then 3.
- Pulse key 1 high for 1 cycle with ack held off. Expect: pend_p and pend_r both set, o_pending[1]=1, press presented first. Ack twice. Expect: release follows, and o_overrun stays 0.
- Toggle key 0 up, down, up while the press is still pending and unacked. Expect: o_overrun=1 and only one press plus one release delivered. A later reset clears o_overrun.
- With i_en=0, toggle all keys. Expect: no o_req and o_pending=0. Set i_en=1 while an earlier request is still pending. Expect: it completes normally.
- Assert i_rst while o_req=1. Expect: next cycle o_req=0, o_pending=0, FSM in IDLE. A key held high through reset gives a press event 2 cycles after reset deasserts.
